// File: rtl/fta_bus_pkg.sv
// rtl/fta_bus_pkg.sv - FTA command bus types, size codes and lane-mask helper
package fta_bus_pkg;

  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_WYDE  = 3'd1,
    SZ_TETRA = 3'd2,
    SZ_OCTA  = 3'd3,
    SZ_HEXI  = 3'd4
  } fta_size_t;

  typedef logic [7:0] fta_tid_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    fta_size_t    sz;
    fta_tid_t     tid;
    logic [31:0]  padr;
    logic [31:0]  vadr;
    logic [31:0]  sel;
    logic [255:0] data1;
  } fta_cmd_request256_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    fta_size_t   sz;
    fta_tid_t    tid;
    logic [31:0] padr;
    logic [31:0] vadr;
    logic [7:0]  sel;
    logic [63:0] dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic         ack;
    logic         err;
    logic         rty;
    logic         stall;
    fta_tid_t     tid;
    logic [31:0]  adr;
    logic [255:0] dat;
  } fta_cmd_response256_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;
    fta_tid_t    tid;
    logic [31:0] adr;
    logic [63:0] dat;
  } fta_cmd_response64_t;

  // A 64-bit lane is active when any of its eight byte selects is set.
  function automatic logic [3:0] lane_mask(input logic [31:0] sel);
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = |sel[8*k +: 8];
    return m;
  endfunction

endpackage

// File: rtl/fta_lane_pick.sv
// rtl/fta_lane_pick.sv - nearest active lane strictly beyond the current one
module fta_lane_pick (
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  input  logic       desc,
  output logic [1:0] nxt,
  output logic       valid
);

  logic [2:0] pos;

  // pos[2] flags walking off either end of the four lanes.
  always_comb begin
    nxt   = cur;
    valid = 1'b0;
    pos   = '0;
    for (int i = 1; i < 4; i++) begin
      pos = desc ? ({1'b0, cur} - 3'(i)) : ({1'b0, cur} + 3'(i));
      if (!valid && !pos[2] && mask[pos[1:0]]) begin
        valid = 1'b1;
        nxt   = pos[1:0];
      end
    end
  end

endmodule

// File: rtl/fta_split256to64.sv
// rtl/fta_split256to64.sv - splits one 256-bit FTA request into 64-bit lane beats
module fta_split256to64
  import fta_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT         = 255,
  parameter bit          LANE_ORDER_DESC = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  fta_cmd_request256_t  req256_i,
  output fta_cmd_response256_t resp256_o,
  output fta_cmd_request64_t   req64_o,
  input  fta_cmd_response64_t  resp64_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int              WDW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [1:0]      EDGE_LANE = LANE_ORDER_DESC ? 2'd3 : 2'd0;

  state_t              state_q, state_d;
  fta_cmd_request256_t req_q;
  logic [3:0]          mask_q, new_mask, pk_mask;
  logic [1:0]          lane_q, lane_d, pk_cur, pk_nxt;
  logic                pk_valid;
  logic [255:0]        rbuf_q;
  logic [WDW-1:0]      wdog_q;
  logic [2:0]          res_q, res_d;
  logic                rsp_valid_q;
  logic                accept, beat_go, hit, timeout;
  logic                unused_bits;

  assign new_mask = lane_mask(req256_i.sel);
  assign accept   = (state_q == IDLE) && req256_i.cyc && req256_i.stb;
  assign beat_go  = (state_q == ISSUE) && !resp64_i.stall;
  assign hit      = (state_q == WAIT) && (resp64_i.tid == req_q.tid) &&
                    (resp64_i.ack || resp64_i.err || resp64_i.rty);
  assign timeout  = (state_q == WAIT) && !hit && (wdog_q == WD_LAST);

  // In IDLE the picker looks ahead from the edge lane to find the first beat.
  assign pk_mask = (state_q == IDLE) ? new_mask : mask_q;
  assign pk_cur  = (state_q == IDLE) ? EDGE_LANE : lane_q;

  fta_lane_pick u_pick (
    .mask  (pk_mask),
    .cur   (pk_cur),
    .desc  (LANE_ORDER_DESC),
    .nxt   (pk_nxt),
    .valid (pk_valid)
  );

  // res_q holds the upstream outcome as {ack, err, rty}; err outranks rty and ack.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (accept) begin
        lane_d = new_mask[EDGE_LANE] ? EDGE_LANE : pk_nxt;
        if (new_mask == 4'b0000) begin
          state_d = RESP;
          res_d   = 3'b100;
        end else begin
          state_d = ISSUE;
          res_d   = 3'b000;
        end
      end
      ISSUE: if (!resp64_i.stall) state_d = WAIT;
      WAIT: begin
        if (hit) begin
          if (resp64_i.err) begin
            res_d   = 3'b010;
            state_d = RESP;
          end else if (resp64_i.rty) begin
            res_d   = 3'b001;
            state_d = RESP;
          end else if (pk_valid) begin
            lane_d  = pk_nxt;
            state_d = ISSUE;
          end else begin
            res_d   = 3'b100;
            state_d = RESP;
          end
        end else if (timeout) begin
          res_d   = 3'b010;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      mask_q      <= '0;
      lane_q      <= '0;
      rbuf_q      <= '0;
      wdog_q      <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      res_q       <= res_d;
      rsp_valid_q <= (state_q == RESP);
      if (accept) begin
        req_q  <= req256_i;
        mask_q <= new_mask;
        rbuf_q <= '0;
      end
      if (beat_go) wdog_q <= '0;
      else if (state_q == WAIT) wdog_q <= wdog_q + WDW'(1);
      if (hit && resp64_i.ack && !resp64_i.err && !resp64_i.rty)
        rbuf_q[{lane_q, 6'd0} +: 64] <= resp64_i.dat;
    end
  end

  always_comb begin
    req64_o = '0;
    if (state_q == ISSUE || state_q == WAIT) begin
      req64_o.cyc  = 1'b1;
      req64_o.stb  = (state_q == ISSUE);
      req64_o.we   = req_q.we;
      req64_o.sz   = req_q.sz;
      req64_o.tid  = req_q.tid;
      req64_o.sel  = req_q.sel[{lane_q, 3'd0} +: 8];
      req64_o.dat  = req_q.data1[{lane_q, 6'd0} +: 64];
      req64_o.padr = {req_q.padr[31:5], lane_q, 3'b000};
      req64_o.vadr = {req_q.vadr[31:5], lane_q, 3'b000};
    end
  end

  // The upstream response is registered out of RESP and held for one cycle.
  always_comb begin
    resp256_o       = '0;
    resp256_o.stall = (state_q != IDLE);
    if (rsp_valid_q) begin
      {resp256_o.ack, resp256_o.err, resp256_o.rty} = res_q;
      resp256_o.tid = req_q.tid;
      resp256_o.adr = req_q.padr;
      resp256_o.dat = rbuf_q;
    end
  end

  assign busy_o = (state_q != IDLE);

  assign unused_bits = ^{resp64_i.adr, req_q.vadr[4:0], req_q.cyc, req_q.stb};

endmodule

// File: doc/fta_split256to64.md
FTA_SPLIT256TO64 -- requirements
Module: fta_split256to64

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: per-beat ack watchdog limit, in clk_i cycles.
REQ-002 SHALL have parameter LANE_ORDER_DESC, default 0: 0 issues lanes ascending, 1 issues lanes descending.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req256_i, input, fta_cmd_request256_t: upstream 256-bit request.
REQ-006 SHALL have port resp256_o, output, fta_cmd_response256_t: upstream response.
REQ-007 SHALL have port req64_o, output, fta_cmd_request64_t: downstream 64-bit request.
REQ-008 SHALL have port resp64_i, input, fta_cmd_response64_t: downstream response.
REQ-009 SHALL have port busy_o, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-011 IDLE: when req256_i.cyc & stb, SHALL latch the whole request and lane mask m[k] = |sel[8k+7:8k] (k=0..3), then go to ISSUE.
REQ-012 IDLE with latched mask 4'b0000 SHALL skip downstream and go to RESP with ack=1, dat=0.
REQ-013 resp256_o.stall SHALL be 1 in every state except IDLE; new requests SHALL be accepted only in IDLE.
REQ-014 ISSUE SHALL drive req64_o with the latched fields and beat overrides:
- cyc=stb=1
- sel=sel[8k+7:8k]
- dat=data1[64k+63:64k]
- padr={padr[31:5],k[1:0],3'b000}, vadr likewise
- tid=latched tid
REQ-015 ISSUE SHALL issue only the active lanes, in the order set by LANE_ORDER_DESC.
REQ-016 ISSUE with resp64_i.stall=1 SHALL hold req64_o unchanged; with stall=0 SHALL go to WAIT, keeping cyc=1 and driving stb=0.
REQ-017 WAIT SHALL act only on responses where resp64_i.tid equals the latched tid; all others SHALL be ignored.
REQ-018 WAIT on a matching ack SHALL store resp64_i.dat into read-buffer lane k, then go to ISSUE for the next active lane, or to RESP if none remain.
REQ-019 WAIT on a matching err or rty SHALL abort the remaining lanes and go to RESP, carrying that flag.
REQ-020 When err and ack arrive together, err SHALL win.
REQ-021 The watchdog counter SHALL clear on each beat issue and increment every cycle in WAIT; reaching TIMEOUT SHALL force RESP with err=1.
REQ-022 RESP SHALL assert, for exactly one cycle:
- resp256_o.ack (or err/rty)
- resp256_o.dat = read buffer (inactive lanes 0)
- resp256_o.tid = latched tid, resp256_o.adr = latched padr
It SHALL then drive req64_o.cyc=0 and return to IDLE.
REQ-023 Latency: with a slave acking one cycle after stb, n active lanes SHALL complete in 2n+2 cycles from acceptance to resp256_o.ack.
REQ-024 Size codes octa and hexi SHALL be accepted with no size error.
REQ-025 In all states other than ISSUE/WAIT, req64_o SHALL be all-zero.

Reset
REQ-026 rst_ni low SHALL immediately force state IDLE and zero req64_o, resp256_o, busy_o, the read buffer and the watchdog.
REQ-027 Reset mid-transfer SHALL abandon the transfer with no upstream response generated.

Structure
REQ-028 Types fta_cmd_request256_t, fta_cmd_request64_t, fta_cmd_response256_t, fta_cmd_response64_t and the size codes SHALL come from fta_bus_pkg.
REQ-029 The FSM state enum SHALL be local to the module.
REQ-030 A sub-module fta_lane_pick SHALL map (4-bit mask, current lane, direction) to (next lane, valid), purely combinationally.

Verification
REQ-031 Bench SHALL cover: sel=32'hFFFFFFFF write, zero-wait slave -> four beats at padr ...00/08/10/18 with sel=8'hFF, then resp ack 10 cycles after acceptance.
REQ-032 Bench SHALL cover: sel=32'h00FF00F0 read, lane data 64'h1111.., 64'h3333.. -> only lanes 0 and 2 issued; resp dat = {64'h0, 64'h3333.., 64'h0, 64'h1111..}.
REQ-033 Bench SHALL cover: sel=0 -> no req64_o.cyc; resp ack with dat=0 two cycles after acceptance.
REQ-034 Bench SHALL cover: beat 1 returns err=1 with ack=1 -> lanes 2-3 not issued; resp err=1, ack=0.
REQ-035 Bench SHALL cover: slave silent, TIMEOUT=8 -> resp err=1 after 8 WAIT cycles, and a foreign-tid ack injected during the wait is ignored.
REQ-036 Bench SHALL cover: rst_ni low during beat 2 -> req64_o.cyc=0 the same cycle, busy_o=0, no resp256_o.ack.
